hh_neuron_scheduler: RTL
========================

Name: hh_neuron_scheduler

Overview:
- Time-multiplexes one shared Hodgkin-Huxley update datapath across N_NEURONS neurons.
- Holds per-neuron state (V, m, h, n) and injected current I in internal register files.
- On each step_tick it sweeps neurons 0..N_NEURONS-1: issues operands to the datapath, waits for results, writes them back, and detects spikes.
- Sits between the network timing/config logic and the membrane/gating update datapath.

Parameters:
- N_NEURONS, 8, neurons served; must be ≥2.
- IDX_W, 3, index width; must be ≥ clog2(N_NEURONS).
- V_REST, 16'hBF00, reset V (−65.0 in Q8.8 signed).
- M_REST, 16'h000D, reset m (≈0.05 in Q8.8).
- H_REST, 16'h009A, reset h (≈0.60 in Q8.8).
- N_REST, 16'h0052, reset n (≈0.32 in Q8.8).
- V_THRESH, 16'h0000, spike threshold (0.0 mV, signed Q8.8).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- step_tick  in  1  one-cycle pulse that starts an integration sweep
- cfg_we  in  1  write strobe for the current register
- cfg_idx  in  IDX_W  neuron index for cfg write
- cfg_I  in  16  input current, signed Q8.8
- dp_req  out  1  operands valid; held until dp_done
- dp_idx  out  IDX_W  neuron being updated
- dp_V, dp_m, dp_h, dp_n, dp_I  out  16 each  operands
- dp_done  in  1  one-cycle pulse: results valid
- dp_V_next, dp_m_next, dp_h_next, dp_n_next  in  16 each  results
- spike_valid  out  1  one-cycle spike event
- spike_idx  out  IDX_W  spiking neuron
- step_done  out  1  one-cycle pulse at end of sweep
- busy  out  1  high while a sweep is in progress
- overrun  out  1  sticky; set when step_tick arrives while busy

Behaviour:
- All data is 16-bit signed Q8.8; values pass through unchanged, with no saturation in this block.
- Reset (async): every neuron to V_REST/M_REST/H_REST/N_REST; all I = 0; FSM to IDLE; all outputs 0, including overrun.
- FSM states:
  - IDLE: on step_tick go to ISSUE with ptr=0 and busy=1.
  - ISSUE (1 cycle): register operands of neuron ptr onto dp_*; go to WAIT with dp_req=1.
  - WAIT: dp_req=1 and operands held stable. On dp_done, capture results, drop dp_req, go to WB.
  - WB (1 cycle): write all four results to neuron ptr. If ptr==N_NEURONS-1 go to DONE, else ptr+1 and go to ISSUE.
  - DONE (1 cycle): step_done=1, busy=0, go to IDLE.
- Minimum per-neuron cost is 3 cycles (ISSUE, WAIT with immediate dp_done, WB). Minimum sweep is 3·N+1 cycles from step_tick to step_done.
- Spike detection in WB: spike_valid=1 and spike_idx=ptr when old V < V_THRESH and dp_V_next ≥ V_THRESH (signed compare). It fires only on the upward crossing and is asserted in the same cycle as the write.
- dp_done outside WAIT is ignored.
- step_tick while busy (ISSUE/WAIT/WB/DONE): the tick is dropped and overrun is set. overrun clears only on rst.
- step_tick in the same cycle that DONE→IDLE is treated as busy: overrun is set and the tick is dropped.
- cfg writes:
  - Accepted in any state, taking effect the next cycle.
  - dp_I is sampled in ISSUE. A write to neuron ptr at or after its ISSUE applies next sweep; a write to neuron ptr in the cycle before its ISSUE is seen.
  - cfg_idx ≥ N_NEURONS is ignored.
- Reset mid-sweep: immediate abort, with dp_req=0 and all state returned to rest. A late dp_done is ignored (IDLE).

Decomposition:
- Shared package hh_pkg: Q8.8 width constant, rest-value constants, V_THRESH, FSM state enum.
- Optional sub-module hh_state_rf: N×64-bit state register file, async reset to rest values, one read port and one write port.
- The I register file and the FSM stay in the top module.

Test Plan:
- Reset then idle: dp_req=0, busy=0, overrun=0. First sweep with the datapath model echoing operands issues dp_V=16'hBF00, dp_m=16'h000D for each idx 0..7 in order, with dp_I=0.
- Full sweep with 0-latency dp_done: step_done exactly 25 cycles after step_tick (N=8); busy high throughout.
- Write cfg_I(3)=16'h0A00, and have the model return dp_V_next=16'h0100 only for idx 3: exactly one spike_valid with spike_idx=3. The next sweep returning 16'h0200 produces no spike.
- Datapath model with 5-cycle dp_done latency: dp_req and operands stable for the whole wait. A spurious dp_done injected in IDLE causes no state change.
- step_tick pulsed mid-sweep: overrun=1, sweep completes once, only one step_done, no second sweep.
- Assert rst while in WAIT for idx 4: dp_req=0 asynchronously. A re-run sweep shows all neurons back at rest values and I=0.

Source files
------------

// File: rtl/hh_neuron_scheduler_pkg.sv
// Shared types and constants for the Hodgkin-Huxley neuron scheduler.
// All quantities are signed Q8.8.
package hh_pkg;

  localparam int Q_W = 16;

  localparam logic [Q_W-1:0] HH_V_REST   = 16'hBF00;
  localparam logic [Q_W-1:0] HH_M_REST   = 16'h000D;
  localparam logic [Q_W-1:0] HH_H_REST   = 16'h009A;
  localparam logic [Q_W-1:0] HH_N_REST   = 16'h0052;
  localparam logic [Q_W-1:0] HH_V_THRESH = 16'h0000;

  // One neuron's gating state, V in the most significant slice.
  typedef struct packed {
    logic [Q_W-1:0] v;
    logic [Q_W-1:0] m;
    logic [Q_W-1:0] h;
    logic [Q_W-1:0] n;
  } hh_state_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WB,
    S_DONE
  } hh_fsm_e;

endpackage

// File: rtl/hh_neuron_scheduler_if.sv
// Operand/result handshake between the scheduler (master) and the shared
// Hodgkin-Huxley update datapath (slave).
interface hh_neuron_scheduler_if
  import hh_pkg::*;
#(
  parameter int IDX_W = 3
) ();

  logic             dp_req;
  logic [IDX_W-1:0] dp_idx;
  logic [Q_W-1:0]   dp_V;
  logic [Q_W-1:0]   dp_m;
  logic [Q_W-1:0]   dp_h;
  logic [Q_W-1:0]   dp_n;
  logic [Q_W-1:0]   dp_I;
  logic             dp_done;
  logic [Q_W-1:0]   dp_V_next;
  logic [Q_W-1:0]   dp_m_next;
  logic [Q_W-1:0]   dp_h_next;
  logic [Q_W-1:0]   dp_n_next;

  modport master (
    output dp_req, dp_idx, dp_V, dp_m, dp_h, dp_n, dp_I,
    input  dp_done, dp_V_next, dp_m_next, dp_h_next, dp_n_next
  );

  modport slave (
    input  dp_req, dp_idx, dp_V, dp_m, dp_h, dp_n, dp_I,
    output dp_done, dp_V_next, dp_m_next, dp_h_next, dp_n_next
  );

endinterface

// File: rtl/hh_neuron_scheduler_state_rf.sv
// Per-neuron (V, m, h, n) register file: one combinational read port,
// one synchronous write port, every entry resets to the resting state.
module hh_state_rf
  import hh_pkg::*;
#(
  parameter int             N_NEURONS = 8,
  parameter int             IDX_W     = 3,
  parameter logic [Q_W-1:0] V_REST    = HH_V_REST,
  parameter logic [Q_W-1:0] M_REST    = HH_M_REST,
  parameter logic [Q_W-1:0] H_REST    = HH_H_REST,
  parameter logic [Q_W-1:0] N_REST    = HH_N_REST
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_waddr,
  input  hh_state_t        i_wdata,
  input  logic [IDX_W-1:0] i_raddr,
  output hh_state_t        o_rdata
);

  localparam hh_state_t LP_REST = {V_REST, M_REST, H_REST, N_REST};

  hh_state_t r_mem [N_NEURONS];

  // NOTE: this array is built from flops rather than a RAM macro because a
  // reset must return every neuron to rest at once, which SRAMs cannot do.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state always uses <= so every flop samples pre-edge values.
    if (rst) begin
      for (int i = 0; i < N_NEURONS; i++) r_mem[i] <= LP_REST;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/hh_neuron_scheduler.sv
// Time-multiplexes one Hodgkin-Huxley update datapath across N_NEURONS neurons.
// Owns the injected-current file and the sweep FSM; gating state lives in hh_state_rf.
module hh_neuron_scheduler
  import hh_pkg::*;
#(
  parameter int             N_NEURONS = 8,
  parameter int             IDX_W     = 3,
  parameter logic [Q_W-1:0] V_REST    = HH_V_REST,
  parameter logic [Q_W-1:0] M_REST    = HH_M_REST,
  parameter logic [Q_W-1:0] H_REST    = HH_H_REST,
  parameter logic [Q_W-1:0] N_REST    = HH_N_REST,
  parameter logic [Q_W-1:0] V_THRESH  = HH_V_THRESH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  step_tick,
  input  logic                  cfg_we,
  input  logic [IDX_W-1:0]      cfg_idx,
  input  logic [Q_W-1:0]        cfg_I,
  hh_neuron_scheduler_if.master dp,
  output logic                  spike_valid,
  output logic [IDX_W-1:0]      spike_idx,
  output logic                  step_done,
  output logic                  busy,
  output logic                  overrun
);

  localparam logic [IDX_W-1:0] LP_LAST = IDX_W'(N_NEURONS - 1);
  localparam logic [IDX_W:0]   LP_N    = (IDX_W + 1)'(N_NEURONS);

  hh_fsm_e          r_state, w_state_nxt;
  logic [IDX_W-1:0] r_ptr;
  logic [Q_W-1:0]   r_cur [N_NEURONS];
  hh_state_t        r_res;
  hh_state_t        w_rd_state;
  logic             w_last;
  logic             w_wb;
  logic             w_cfg_ok;

  assign w_last   = (r_ptr == LP_LAST);
  assign w_wb     = (r_state == S_WB);
  assign w_cfg_ok = cfg_we && ({1'b0, cfg_idx} < LP_N);

  hh_state_rf #(
    .N_NEURONS (N_NEURONS),
    .IDX_W     (IDX_W),
    .V_REST    (V_REST),
    .M_REST    (M_REST),
    .H_REST    (H_REST),
    .N_REST    (N_REST)
  ) u_state_rf (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_wb),
    .i_waddr (r_ptr),
    .i_wdata (r_res),
    .i_raddr (r_ptr),
    .o_rdata (w_rd_state)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path infers a latch.
    w_state_nxt = r_state;
    dp.dp_req   = 1'b0;
    busy        = 1'b0;
    step_done   = 1'b0;
    spike_valid = 1'b0;
    spike_idx   = '0;
    unique case (r_state)
      S_IDLE:  if (step_tick) w_state_nxt = S_ISSUE;
      S_ISSUE: begin
        busy        = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        busy      = 1'b1;
        dp.dp_req = 1'b1;
        if (dp.dp_done) w_state_nxt = S_WB;
      end
      S_WB: begin
        busy        = 1'b1;
        w_state_nxt = w_last ? S_DONE : S_ISSUE;
        // dp_V still holds this neuron's pre-update V: upward crossings only.
        if ($signed(dp.dp_V) < $signed(V_THRESH) &&
            $signed(r_res.v) >= $signed(V_THRESH)) begin
          spike_valid = 1'b1;
          spike_idx   = r_ptr;
        end
      end
      S_DONE: begin
        step_done   = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr     <= '0;
      dp.dp_idx <= '0;
      dp.dp_V   <= '0;
      dp.dp_m   <= '0;
      dp.dp_h   <= '0;
      dp.dp_n   <= '0;
      dp.dp_I   <= '0;
      r_res     <= '0;
    end else begin
      case (r_state)
        S_IDLE:  if (step_tick) r_ptr <= '0;
        S_ISSUE: begin
          dp.dp_idx <= r_ptr;
          dp.dp_V   <= w_rd_state.v;
          dp.dp_m   <= w_rd_state.m;
          dp.dp_h   <= w_rd_state.h;
          dp.dp_n   <= w_rd_state.n;
          dp.dp_I   <= r_cur[r_ptr];
        end
        S_WAIT:  if (dp.dp_done) r_res <= {dp.dp_V_next, dp.dp_m_next, dp.dp_h_next, dp.dp_n_next};
        S_WB:    if (!w_last) r_ptr <= r_ptr + IDX_W'(1);
        default: ;
      endcase
    end
  end

  // Current is sampled at ISSUE, so a write lands for the neuron only if it precedes that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_NEURONS; i++) r_cur[i] <= '0;
    end else if (w_cfg_ok) begin
      r_cur[cfg_idx] <= cfg_I;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               overrun <= 1'b0;
    else if (step_tick && r_state != S_IDLE) overrun <= 1'b1;
  end

endmodule
